// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    // Width of the memory latency down-counter (MEM_LATENCY up to 15).
    localparam int CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, data and memory-side signals around the arbiter.
// The slave modport is the arbiter's view; master is everything around it.
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    // fetch stage
    logic                    if_req;
    logic [ADDR_WIDTH-1:0]   if_addr;
    logic                    if_flush;
    logic                    if_done;
    logic [DATA_WIDTH-1:0]   if_rdata;
    // memory stage
    logic                    d_req;
    logic                    d_we;
    logic [DATA_WIDTH/8-1:0] d_be;
    logic [ADDR_WIDTH-1:0]   d_addr;
    logic [DATA_WIDTH-1:0]   d_wdata;
    logic                    d_done;
    logic [DATA_WIDTH-1:0]   d_rdata;
    // memory
    logic                    mem_req;
    logic                    mem_we;
    logic [DATA_WIDTH/8-1:0] mem_be;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [DATA_WIDTH-1:0]   mem_rdata;
    // pipeline status
    logic                    stall_if;
    logic                    stall_mem;
    logic                    busy;

    modport slave (
        input  if_req, if_addr, if_flush,
        input  d_req, d_we, d_be, d_addr, d_wdata,
        input  mem_rdata,
        output if_done, if_rdata,
        output d_done, d_rdata,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output stall_if, stall_mem, busy
    );

    modport master (
        output if_req, if_addr, if_flush,
        output d_req, d_we, d_be, d_addr, d_wdata,
        output mem_rdata,
        input  if_done, if_rdata,
        input  d_done, d_rdata,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  stall_if, stall_mem, busy
    );

endinterface

// File: rtl/arb_latency_timer.sv
// Down-counter that tracks the remaining cycles of a fixed-latency memory access.
module arb_latency_timer
    import mem_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    // Load on issue, then count down to zero and hold there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported unified memory between the fetch stage and the
// memory stage. Data wins by default; a starvation counter lets a waiting fetch
// through after STARVE_LIMIT consecutive data grants. A branch redirect can
// cancel an in-flight fetch: the memory access still runs, only if_done is hidden.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               rstn,
    mem_port_arbiter_if.slave  bus
);

    localparam int BE_W = DATA_WIDTH / 8;
    localparam int SC_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [SC_W-1:0]  STARVE_MAX = SC_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] LAT_LOAD   = CNT_W'(MEM_LATENCY - 1);

    arb_state_t            state;
    arb_state_t            state_nxt;
    owner_t                owner;
    logic                  drop;
    logic [SC_W-1:0]       starve_cnt;

    logic [ADDR_WIDTH-1:0] lat_addr;
    logic                  lat_we;
    logic [BE_W-1:0]       lat_be;
    logic [DATA_WIDTH-1:0] lat_wdata;

    logic                  grant_d;
    logic                  grant_if;
    logic                  timer_zero;
    logic                  xfer_done;

    arb_latency_timer u_timer (
        .clk      (clk),
        .rst      (rstn),
        .load     (state == ISSUE),
        .load_val (LAT_LOAD),
        .dec      (state == WAIT),
        .zero     (timer_zero)
    );

    assign xfer_done = (state == WAIT) && timer_zero;

    // Grant decision, only meaningful while idle; data first unless fetch is starving.
    always_comb begin
        grant_d  = 1'b0;
        grant_if = 1'b0;
        if (state == IDLE) begin
            grant_d  = bus.d_req && (!bus.if_req || (starve_cnt < STARVE_MAX));
            grant_if = !grant_d && bus.if_req && !bus.if_flush;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: idle -> one issue cycle -> wait out the memory latency.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_d || grant_if) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (timer_zero) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Capture the winning requester's fields so later input changes cannot disturb the access.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            owner     <= OWN_IF;
            lat_addr  <= '0;
            lat_we    <= 1'b0;
            lat_be    <= '0;
            lat_wdata <= '0;
        end else if (grant_d) begin
            owner     <= OWN_D;
            lat_addr  <= bus.d_addr;
            lat_we    <= bus.d_we;
            lat_be    <= bus.d_be;
            lat_wdata <= bus.d_wdata;
        end else if (grant_if) begin
            owner     <= OWN_IF;
            lat_addr  <= bus.if_addr;
            lat_we    <= 1'b0;
            lat_be    <= '1;
            lat_wdata <= '0;
        end
    end

    // Remember a redirect that arrived while our fetch was in flight; forget it once idle.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            drop <= 1'b0;
        end else if (state == IDLE) begin
            drop <= 1'b0;
        end else if ((owner == OWN_IF) && bus.if_flush) begin
            drop <= 1'b1;
        end
    end

    // Count data grants that overtook a waiting fetch; saturate at the limit.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            starve_cnt <= '0;
        end else if (grant_d && bus.if_req) begin
            if (starve_cnt < STARVE_MAX) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end else if (grant_if || !bus.if_req) begin
            starve_cnt <= '0;
        end
    end

    // FSM outputs: memory strobe, completion pulses with pass-through read data, stalls.
    always_comb begin
        bus.mem_req   = (state == ISSUE);
        bus.mem_we    = (state == ISSUE) && (owner == OWN_D) && lat_we;
        bus.mem_be    = '0;
        if (state == ISSUE) begin
            bus.mem_be = (owner == OWN_IF) ? '1 : lat_be;
        end
        bus.mem_addr  = lat_addr;
        bus.mem_wdata = lat_wdata;

        bus.if_done   = xfer_done && (owner == OWN_IF) && !drop && !bus.if_flush;
        bus.if_rdata  = bus.if_done ? bus.mem_rdata : '0;
        bus.d_done    = xfer_done && (owner == OWN_D);
        bus.d_rdata   = (bus.d_done && !lat_we) ? bus.mem_rdata : '0;

        bus.stall_if  = bus.if_req && !bus.if_done;
        bus.stall_mem = bus.d_req && !bus.d_done;
        bus.busy      = (state != IDLE);
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized
// run scored against a transaction-level scheduling model.
module tb_mem_port_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int BW   = DW / 8;
    localparam int LAT  = 2;
    localparam int SLIM = 2;

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    int tests_run    = 0;
    int tests_failed = 0;

    mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mem_port_arbiter #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .MEM_LATENCY  (LAT),
        .STARVE_LIMIT (SLIM)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Fixed-latency memory: 256 words, data valid exactly LAT cycles after mem_req.
    logic [DW-1:0] mem [256];
    logic [DW-1:0] rd_pipe [LAT];
    logic          mem_ready = 1'b0;

    function automatic logic [DW-1:0] init_word(int i);
        if (i == 4) return 32'h00500093;
        return 32'hC0DE0000 ^ (32'(i) * 32'h00010001);
    endfunction

    function automatic logic [DW-1:0] merge_be(logic [DW-1:0] old_w, logic [DW-1:0] new_w,
                                               logic [BW-1:0] be);
        logic [DW-1:0] r;
        r = old_w;
        for (int b = 0; b < BW; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    assign bus.mem_rdata = rd_pipe[LAT-1];

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
            for (int i = 0; i < LAT; i++) rd_pipe[i] <= '0;
            mem_ready <= 1'b1;
        end else begin
            if (bus.mem_req && bus.mem_we)
                mem[bus.mem_addr[9:2]] <= merge_be(mem[bus.mem_addr[9:2]], bus.mem_wdata, bus.mem_be);
            for (int i = LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
            rd_pipe[0] <= (bus.mem_req && !bus.mem_we) ? mem[bus.mem_addr[9:2]] : $urandom;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.if_req = 0; bus.if_addr = '0; bus.if_flush = 0;
        bus.d_req = 0; bus.d_we = 0; bus.d_be = '0; bus.d_addr = '0; bus.d_wdata = '0;
        rstn = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if ({bus.mem_req, bus.mem_we, bus.mem_be, bus.if_done, bus.d_done, bus.busy} !== 9'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_ctrl: got %b expected 0",
                     {bus.mem_req, bus.mem_we, bus.mem_be, bus.if_done, bus.d_done, bus.busy});
        end
        tests_run++;
        if ({bus.mem_addr, bus.mem_wdata} !== 64'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_bus: got %h expected 0", {bus.mem_addr, bus.mem_wdata});
        end
        bus.if_req = 1; bus.d_req = 1;
        #1;
        tests_run++;
        if ({bus.stall_if, bus.stall_mem, bus.mem_req, bus.busy} !== 4'b1100) begin
            tests_failed++;
            $display("[TB] FAIL reset_stalls: got %b expected 1100",
                     {bus.stall_if, bus.stall_mem, bus.mem_req, bus.busy});
        end
        bus.if_req = 0; bus.d_req = 0;
        rstn = 1'b0;
        next_cycle();
    endtask

    task automatic test_single_fetch();
        for (int k = 0; k < 5; k++) begin
            if (k == 0) begin bus.if_req = 1; bus.if_addr = 32'h10; end
            if (k == 4) bus.if_req = 0;
            @(negedge clk);
            tests_run++;
            if ({bus.mem_req, bus.if_done, bus.stall_if, bus.busy} !==
                {k == 1, k == 3, k < 3, (k >= 1 && k <= 3)}) begin
                tests_failed++;
                $display("[TB] FAIL fetch_ctrl k=%0d: got %b expected %b", k,
                         {bus.mem_req, bus.if_done, bus.stall_if, bus.busy},
                         {k == 1, k == 3, k < 3, (k >= 1 && k <= 3)});
            end
            if (k == 1) begin
                tests_run++;
                if ({bus.mem_addr, bus.mem_we, bus.mem_be} !== {32'h10, 1'b0, 4'hF}) begin
                    tests_failed++;
                    $display("[TB] FAIL fetch_issue: got %h expected %h",
                             {bus.mem_addr, bus.mem_we, bus.mem_be}, {32'h10, 1'b0, 4'hF});
                end
            end
            tests_run++;
            if (bus.if_rdata !== ((k == 3) ? 32'h00500093 : 32'h0)) begin
                tests_failed++;
                $display("[TB] FAIL fetch_rdata k=%0d: got %h expected %h", k, bus.if_rdata,
                         (k == 3) ? 32'h00500093 : 32'h0);
            end
            next_cycle();
        end
    endtask

    task automatic test_simultaneous();
        logic [DW-1:0] exp_d;
        exp_d = mem[32];
        for (int k = 0; k < 9; k++) begin
            if (k == 0) begin
                bus.if_req = 1; bus.if_addr = 32'h10;
                bus.d_req = 1; bus.d_we = 0; bus.d_be = 4'h0; bus.d_addr = 32'h80;
            end
            if (k == 4) bus.d_req = 0;
            if (k == 8) bus.if_req = 0;
            @(negedge clk);
            tests_run++;
            if ({bus.mem_req, bus.d_done, bus.if_done, bus.stall_mem, bus.stall_if} !==
                {(k == 1 || k == 5), k == 3, k == 7, k < 3, k < 7}) begin
                tests_failed++;
                $display("[TB] FAIL simul_ctrl k=%0d: got %b expected %b", k,
                         {bus.mem_req, bus.d_done, bus.if_done, bus.stall_mem, bus.stall_if},
                         {(k == 1 || k == 5), k == 3, k == 7, k < 3, k < 7});
            end
            if (k == 1 || k == 5) begin
                tests_run++;
                if (bus.mem_addr !== ((k == 1) ? 32'h80 : 32'h10)) begin
                    tests_failed++;
                    $display("[TB] FAIL simul_addr k=%0d: got %h expected %h", k, bus.mem_addr,
                             (k == 1) ? 32'h80 : 32'h10);
                end
            end
            if (k == 3) begin
                tests_run++;
                if (bus.d_rdata !== exp_d) begin
                    tests_failed++;
                    $display("[TB] FAIL simul_drdata: got %h expected %h", bus.d_rdata, exp_d);
                end
            end
            if (k == 7) begin
                tests_run++;
                if (bus.if_rdata !== 32'h00500093) begin
                    tests_failed++;
                    $display("[TB] FAIL simul_irdata: got %h expected 00500093", bus.if_rdata);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_store();
        logic [DW-1:0] old_w;
        old_w = mem[33];
        for (int k = 0; k < 5; k++) begin
            if (k == 0) begin
                bus.d_req = 1; bus.d_we = 1; bus.d_be = 4'b0011;
                bus.d_addr = 32'h84; bus.d_wdata = 32'hDEADBEEF;
            end
            if (k == 2) begin bus.d_we = 0; bus.d_wdata = 32'h0; end
            if (k == 4) bus.d_req = 0;
            @(negedge clk);
            tests_run++;
            if ({bus.mem_req, bus.mem_we, bus.d_done, bus.d_rdata} !==
                {k == 1, k == 1, k == 3, 32'h0}) begin
                tests_failed++;
                $display("[TB] FAIL store_ctrl k=%0d: got %h expected %h", k,
                         {bus.mem_req, bus.mem_we, bus.d_done, bus.d_rdata},
                         {k == 1, k == 1, k == 3, 32'h0});
            end
            if (k == 1) begin
                tests_run++;
                if ({bus.mem_be, bus.mem_addr, bus.mem_wdata} !== {4'b0011, 32'h84, 32'hDEADBEEF}) begin
                    tests_failed++;
                    $display("[TB] FAIL store_issue: got %h expected %h",
                             {bus.mem_be, bus.mem_addr, bus.mem_wdata}, {4'b0011, 32'h84, 32'hDEADBEEF});
                end
            end
            next_cycle();
        end
        // read back: only the two low bytes were written
        for (int k = 0; k < 5; k++) begin
            if (k == 0) begin bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h84; end
            if (k == 4) bus.d_req = 0;
            @(negedge clk);
            if (k == 3) begin
                tests_run++;
                if ({bus.d_done, bus.d_rdata} !== {1'b1, old_w[31:16], 16'hBEEF}) begin
                    tests_failed++;
                    $display("[TB] FAIL store_readback: got %h expected %h",
                             {bus.d_done, bus.d_rdata}, {1'b1, old_w[31:16], 16'hBEEF});
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_starvation();
        logic [3:0] order;
        int n, cyc, d_dones;
        order = '0; n = 0; cyc = 0;
        bus.if_req = 1; bus.if_addr = 32'h20;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h100;
        while (n < 4 && cyc < 60) begin
            @(negedge clk);
            if (bus.mem_req) begin
                order[n] = (bus.mem_addr != 32'h20);
                n++;
            end
            if (bus.d_done) bus.d_addr = bus.d_addr + 32'h4;
            next_cycle();
            cyc++;
        end
        tests_run++;
        if (n != 4) begin
            tests_failed++;
            $display("[TB] FAIL starve_timeout: got %0d grants expected 4", n);
        end
        tests_run++;
        if (order !== 4'b1011) begin
            tests_failed++;
            $display("[TB] FAIL starve_order (bit0 first, 1=D): got %b expected 1011", order);
        end
        // both requesters give up; the in-flight load must still complete
        bus.if_req = 0; bus.d_req = 0;
        d_dones = 0; cyc = 0;
        while (cyc < 10) begin
            @(negedge clk);
            if (bus.d_done) d_dones++;
            next_cycle();
            cyc++;
        end
        tests_run++;
        if ({d_dones, bus.busy} !== {32'd1, 1'b0}) begin
            tests_failed++;
            $display("[TB] FAIL starve_drain: got dones=%0d busy=%b expected dones=1 busy=0",
                     d_dones, bus.busy);
        end
    endtask

    task automatic test_flush();
        logic [DW-1:0] exp_40;
        exp_40 = mem[16];
        for (int k = 0; k < 14; k++) begin
            if (k == 0) begin bus.if_req = 1; bus.if_addr = 32'h10; end
            if (k == 2) bus.if_flush = 1;
            if (k == 3) begin bus.if_flush = 0; bus.if_req = 0; end
            if (k == 4) begin bus.if_req = 1; bus.if_addr = 32'h40; end
            if (k == 8) begin bus.if_req = 1; bus.if_addr = 32'h10; bus.if_flush = 1; end
            if (k == 9) bus.if_flush = 0;
            if (k == 13) bus.if_req = 0;
            @(negedge clk);
            tests_run++;
            if ({bus.mem_req, bus.if_done, bus.busy} !==
                {(k == 1 || k == 5 || k == 10), (k == 7 || k == 12),
                 ((k >= 1 && k <= 3) || (k >= 5 && k <= 7) || (k >= 10 && k <= 12))}) begin
                tests_failed++;
                $display("[TB] FAIL flush_ctrl k=%0d: got %b expected %b", k,
                         {bus.mem_req, bus.if_done, bus.busy},
                         {(k == 1 || k == 5 || k == 10), (k == 7 || k == 12),
                          ((k >= 1 && k <= 3) || (k >= 5 && k <= 7) || (k >= 10 && k <= 12))});
            end
            if (k == 3 || k == 7) begin
                tests_run++;
                if (bus.if_rdata !== ((k == 7) ? exp_40 : 32'h0)) begin
                    tests_failed++;
                    $display("[TB] FAIL flush_rdata k=%0d: got %h expected %h", k, bus.if_rdata,
                             (k == 7) ? exp_40 : 32'h0);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [DW-1:0] exp_d;
        exp_d = mem[34];
        for (int k = 0; k < 9; k++) begin
            if (k == 0) begin bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h88; end
            if (k == 2) rstn = 1'b1;
            if (k == 4) rstn = 1'b0;
            if (k == 8) bus.d_req = 0;
            @(negedge clk);
            tests_run++;
            if ({bus.mem_req, bus.d_done, bus.busy, bus.stall_mem} !==
                {(k == 1 || k == 5), k == 7, (k == 1 || (k >= 5 && k <= 7)), k < 7}) begin
                tests_failed++;
                $display("[TB] FAIL rstwait_ctrl k=%0d: got %b expected %b", k,
                         {bus.mem_req, bus.d_done, bus.busy, bus.stall_mem},
                         {(k == 1 || k == 5), k == 7, (k == 1 || (k >= 5 && k <= 7)), k < 7});
            end
            if (k == 2) begin
                tests_run++;
                if ({bus.mem_addr, bus.mem_wdata, bus.mem_be, bus.mem_we, bus.d_rdata} !== '0) begin
                    tests_failed++;
                    $display("[TB] FAIL rstwait_bus: got %h expected 0",
                             {bus.mem_addr, bus.mem_wdata, bus.mem_be, bus.mem_we, bus.d_rdata});
                end
            end
            if (k == 7) begin
                tests_run++;
                if (bus.d_rdata !== exp_d) begin
                    tests_failed++;
                    $display("[TB] FAIL rstwait_rdata: got %h expected %h", bus.d_rdata, exp_d);
                end
            end
            next_cycle();
        end
    endtask

    // Random traffic: the model schedules whole transactions by arithmetic on cycle numbers.
    task automatic test_random();
        int c, m_issue, m_done, m_free, m_starve;
        bit m_own_d, f_act, d_act, want_d, grant_f;
        logic [AW-1:0] m_addr;
        logic [DW-1:0] m_wdata, m_rdata;
        logic m_we;
        logic [BW-1:0] m_be;
        logic exp_if_done, exp_d_done;
        c = 0; m_issue = -1; m_done = -1; m_free = 0; m_starve = 0;
        m_own_d = 0; f_act = 0; d_act = 0;
        m_addr = '0; m_wdata = '0; m_rdata = '0; m_we = 0; m_be = '0;
        while (c < 600) begin
            if (c < 500) begin
                if (!f_act && $urandom_range(0, 2) == 0) begin
                    f_act = 1;
                    bus.if_addr = 32'($urandom_range(0, 255)) << 2;
                end
                if (!d_act && $urandom_range(0, 2) == 0) begin
                    d_act = 1;
                    bus.d_we = 1'($urandom_range(0, 1));
                    bus.d_be = 4'($urandom_range(1, 15));
                    bus.d_addr = 32'($urandom_range(0, 255)) << 2;
                    bus.d_wdata = $urandom;
                end
            end
            bus.if_req = f_act;
            bus.d_req = d_act;
            @(negedge clk);
            exp_if_done = (c == m_done) && !m_own_d;
            exp_d_done  = (c == m_done) && m_own_d;
            tests_run++;
            if ({bus.mem_req, bus.if_done, bus.d_done} !== {c == m_issue, exp_if_done, exp_d_done}) begin
                tests_failed++;
                $display("[TB] FAIL rand_ctrl c=%0d: got %b expected %b", c,
                         {bus.mem_req, bus.if_done, bus.d_done}, {c == m_issue, exp_if_done, exp_d_done});
            end
            if (c == m_issue) begin
                tests_run++;
                if ({bus.mem_addr, bus.mem_we, bus.mem_be, bus.mem_wdata} !== {m_addr, m_we, m_be, m_wdata}) begin
                    tests_failed++;
                    $display("[TB] FAIL rand_issue c=%0d: got %h expected %h", c,
                             {bus.mem_addr, bus.mem_we, bus.mem_be, bus.mem_wdata}, {m_addr, m_we, m_be, m_wdata});
                end
            end
            tests_run++;
            if ({bus.if_rdata, bus.d_rdata} !==
                {exp_if_done ? m_rdata : 32'h0, (exp_d_done && !m_we) ? m_rdata : 32'h0}) begin
                tests_failed++;
                $display("[TB] FAIL rand_rdata c=%0d: got %h expected %h", c, {bus.if_rdata, bus.d_rdata},
                         {exp_if_done ? m_rdata : 32'h0, (exp_d_done && !m_we) ? m_rdata : 32'h0});
            end
            if (c >= m_free) begin
                want_d  = d_act && (!f_act || m_starve < SLIM);
                grant_f = !want_d && f_act;
                if (want_d) begin
                    m_own_d = 1; m_addr = bus.d_addr; m_we = bus.d_we;
                    m_be = bus.d_be; m_wdata = bus.d_wdata; m_rdata = mem[bus.d_addr[9:2]];
                end else if (grant_f) begin
                    m_own_d = 0; m_addr = bus.if_addr; m_we = 0;
                    m_be = 4'hF; m_wdata = '0; m_rdata = mem[bus.if_addr[9:2]];
                end
                if (want_d || grant_f) begin
                    m_issue = c + 1; m_done = c + 1 + LAT; m_free = c + 2 + LAT;
                end
                if (want_d && f_act) m_starve = (m_starve < SLIM) ? m_starve + 1 : SLIM;
                else if (grant_f || !f_act) m_starve = 0;
            end else if (!f_act) begin
                m_starve = 0;
            end
            if (bus.if_done) f_act = 0;
            if (bus.d_done) d_act = 0;
            next_cycle();
            c++;
        end
        tests_run++;
        if ({f_act, d_act, bus.busy} !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL rand_drain: got %b expected 000", {f_act, d_act, bus.busy});
        end
        bus.if_req = 0; bus.d_req = 0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_single_fetch();
        test_simultaneous();
        test_store();
        test_starvation();
        test_flush();
        test_reset_mid_wait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
